// File: rtl/id_ex_stage_if.sv
// ID/EX stage bundle: ID handshake, scoreboard hooks, redirect and EX head.
// Perf counter signals exist only when ID_EX_PERF_EN is defined.
interface id_ex_stage_if #(
    parameter int XLEN = 32
);
    logic            id_valid;
    logic            id_ready;
    logic [XLEN-1:0] id_pc;
    logic [XLEN-1:0] id_inst;
    logic [4:0]      id_rd;
    logic            id_rf_wen;
    logic            sb_stall;
    logic            sb_ex_ready;
    logic            redirect;
    logic            ex_valid;
    logic            ex_ready;
    logic [XLEN-1:0] ex_pc;
    logic [XLEN-1:0] ex_inst;
    logic [4:0]      ex_rd;
    logic            ex_rf_wen;
    logic            ex_kill;
`ifdef ID_EX_PERF_EN
    logic [31:0]     perf_stall_cnt;
    logic [31:0]     perf_full_cnt;
    logic [31:0]     perf_kill_cnt;

    modport master (
        output id_valid, id_pc, id_inst, id_rd, id_rf_wen,
        output sb_stall, redirect, ex_ready,
        input  id_ready, sb_ex_ready,
        input  ex_valid, ex_pc, ex_inst, ex_rd, ex_rf_wen, ex_kill,
        input  perf_stall_cnt, perf_full_cnt, perf_kill_cnt
    );

    modport slave (
        input  id_valid, id_pc, id_inst, id_rd, id_rf_wen,
        input  sb_stall, redirect, ex_ready,
        output id_ready, sb_ex_ready,
        output ex_valid, ex_pc, ex_inst, ex_rd, ex_rf_wen, ex_kill,
        output perf_stall_cnt, perf_full_cnt, perf_kill_cnt
    );
`else
    modport master (
        output id_valid, id_pc, id_inst, id_rd, id_rf_wen,
        output sb_stall, redirect, ex_ready,
        input  id_ready, sb_ex_ready,
        input  ex_valid, ex_pc, ex_inst, ex_rd, ex_rf_wen, ex_kill
    );

    modport slave (
        input  id_valid, id_pc, id_inst, id_rd, id_rf_wen,
        input  sb_stall, redirect, ex_ready,
        output id_ready, sb_ex_ready,
        output ex_valid, ex_pc, ex_inst, ex_rd, ex_rf_wen, ex_kill
    );
`endif
endinterface

// File: rtl/id_ex_stage.sv
// ID->EX 2-entry in-order skid buffer with redirect kill marking.
// Optional perf counters enabled by defining ID_EX_PERF_EN.
module id_ex_stage #(
    parameter int XLEN       = 32,
    parameter int DEPTH_LOG2 = 1
) (
    input  logic         clock,
    input  logic         reset,
    id_ex_stage_if.slave bus
);
    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] inst;
        logic [4:0]      rd;
        logic            rf_wen;
        logic            kill;
    } entry_t;

    localparam logic [1:0] FULL = 2'(1 << DEPTH_LOG2);

    entry_t     r_e0;
    entry_t     r_e1;
    entry_t     w_e0_n;
    entry_t     w_e1_n;
    entry_t     w_new;
    logic [1:0] r_count;
    logic [1:0] w_count_n;
    logic       w_sb_ex_ready;
    logic       w_id_ready;
    logic       w_ex_valid;
    logic       w_enq;
    logic       w_deq;

    // Full blocks enq even if EX drains this cycle: no ex_ready->id_ready path
    assign w_sb_ex_ready = !reset && (r_count != FULL) && !bus.redirect;
    assign w_id_ready    = w_sb_ex_ready && !bus.sb_stall;
    assign w_ex_valid    = (r_count != 2'd0);
    assign w_enq         = bus.id_valid && w_id_ready;
    assign w_deq         = w_ex_valid && bus.ex_ready;

    always_comb begin
        w_e0_n    = r_e0;
        w_e1_n    = r_e1;
        w_count_n = r_count;
        w_new     = '{pc: bus.id_pc, inst: bus.id_inst, rd: bus.id_rd,
                      rf_wen: bus.id_rf_wen, kill: 1'b0};
        unique case ({w_enq, w_deq})
            2'b10: begin
                if (r_count == 2'd0) w_e0_n = w_new;
                else                 w_e1_n = w_new;
                w_count_n = r_count + 2'd1;
            end
            2'b01: begin
                if (r_count == FULL) w_e0_n = r_e1;
                w_count_n = r_count - 2'd1;
            end
            2'b11: begin
                if (r_count == FULL) begin
                    w_e0_n = r_e1;
                    w_e1_n = w_new;
                end else begin
                    w_e0_n = w_new;
                end
            end
            default: ;
        endcase
        // Only surviving valid entries are marked, so an empty head holds
        if (bus.redirect) begin
            if (w_count_n != 2'd0) w_e0_n.kill = 1'b1;
            if (w_count_n == FULL) w_e1_n.kill = 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_e0    <= '0;
            r_e1    <= '0;
            r_count <= 2'd0;
        end else begin
            r_e0    <= w_e0_n;
            r_e1    <= w_e1_n;
            r_count <= w_count_n;
        end
    end

    assign bus.sb_ex_ready = w_sb_ex_ready;
    assign bus.id_ready    = w_id_ready;
    assign bus.ex_valid    = w_ex_valid;
    assign bus.ex_pc       = r_e0.pc;
    assign bus.ex_inst     = r_e0.inst;
    assign bus.ex_rd       = r_e0.rd;
    assign bus.ex_rf_wen   = r_e0.rf_wen;
    assign bus.ex_kill     = r_e0.kill;

`ifdef ID_EX_PERF_EN
    logic [31:0] r_perf_stall;
    logic [31:0] r_perf_full;
    logic [31:0] r_perf_kill;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_perf_stall <= '0;
            r_perf_full  <= '0;
            r_perf_kill  <= '0;
        end else begin
            if (bus.id_valid && bus.sb_stall)
                r_perf_stall <= r_perf_stall + 32'd1;
            if (bus.id_valid && (r_count == FULL))
                r_perf_full <= r_perf_full + 32'd1;
            if (w_deq && r_e0.kill)
                r_perf_kill <= r_perf_kill + 32'd1;
        end
    end

    assign bus.perf_stall_cnt = r_perf_stall;
    assign bus.perf_full_cnt  = r_perf_full;
    assign bus.perf_kill_cnt  = r_perf_kill;
`endif
endmodule

// File: tb/tb_id_ex_stage.sv
// Scoreboard bench for id_ex_stage: directed vectors push expected entries,
// a negedge monitor compares the EX head and handshake outputs.
module tb_id_ex_stage;
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
        logic [4:0]  rd;
        logic        wen;
        logic        kill;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic rst_q = 1'b1;
    int   n_chk = 0;
    int   n_err = 0;
    exp_t q[$];
    exp_t last = '0;
    logic [31:0] m_stall = 0;
    logic [31:0] m_full = 0;
    logic [31:0] m_kill = 0;

    id_ex_stage_if #(.XLEN(32)) bus ();

    id_ex_stage #(.XLEN(32), .DEPTH_LOG2(1)) dut (
        .clock (clk),
        .reset (rst),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    function automatic void chk(string nm, logic [31:0] act,
                                logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp,
                     $time);
        end
    endfunction

    // Reference model of queue contents, updated on the same edge as the DUT
    always @(posedge clk) begin
        rst_q <= rst;
        if (rst) begin
            q.delete();
            m_stall = 0;
            m_full = 0;
            m_kill = 0;
        end else begin
            logic acc;
            logic dq;
            exp_t t;
            acc = bus.id_valid && (q.size() < 2) && !bus.redirect
                  && !bus.sb_stall;
            dq = (q.size() != 0) && bus.ex_ready;
            if (bus.id_valid && bus.sb_stall) m_stall = m_stall + 1;
            if (bus.id_valid && q.size() == 2) m_full = m_full + 1;
            if (dq && q[0].kill) m_kill = m_kill + 1;
            if (dq) void'(q.pop_front());
            if (bus.redirect) begin
                for (int i = 0; i < q.size(); i++) begin
                    t = q[i];
                    t.kill = 1'b1;
                    q[i] = t;
                end
            end
            if (acc) begin
                t = '{pc: bus.id_pc, inst: bus.id_inst, rd: bus.id_rd,
                      wen: bus.id_rf_wen, kill: 1'b0};
                q.push_back(t);
            end
        end
    end

    always @(negedge clk) begin
        exp_t h;
        logic sbr;
        if (rst) begin
            chk("rst_id_ready", 32'(bus.id_ready), 32'd0);
            chk("rst_sb_ex_ready", 32'(bus.sb_ex_ready), 32'd0);
        end else begin
            sbr = (q.size() < 2) && !bus.redirect;
            chk("id_ready", 32'(bus.id_ready), 32'(sbr && !bus.sb_stall));
            chk("sb_ex_ready", 32'(bus.sb_ex_ready), 32'(sbr));
        end
        if (rst_q) begin
            last = '0;
            chk("rst_ex_valid", 32'(bus.ex_valid), 32'd0);
            chk("rst_ex_kill", 32'(bus.ex_kill), 32'd0);
            chk("rst_ex_rf_wen", 32'(bus.ex_rf_wen), 32'd0);
            chk("rst_ex_rd", 32'(bus.ex_rd), 32'd0);
            chk("rst_ex_pc", bus.ex_pc, 32'd0);
            chk("rst_ex_inst", bus.ex_inst, 32'd0);
        end else begin
            chk("ex_valid", 32'(bus.ex_valid), 32'(q.size() != 0));
            h = (q.size() != 0) ? q[0] : last;
            chk("ex_pc", bus.ex_pc, h.pc);
            chk("ex_inst", bus.ex_inst, h.inst);
            chk("ex_rd", 32'(bus.ex_rd), 32'(h.rd));
            chk("ex_rf_wen", 32'(bus.ex_rf_wen), 32'(h.wen));
            chk("ex_kill", 32'(bus.ex_kill), 32'(h.kill));
            if (q.size() != 0) last = q[0];
        end
`ifdef ID_EX_PERF_EN
        chk("perf_stall", bus.perf_stall_cnt, m_stall);
        chk("perf_full", bus.perf_full_cnt, m_full);
        chk("perf_kill", bus.perf_kill_cnt, m_kill);
`endif
    end

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send(input logic [31:0] pc, input logic [4:0] rd,
                        input logic wen);
        logic acc;
        acc = 1'b0;
        bus.id_valid  = 1'b1;
        bus.id_pc     = pc;
        bus.id_inst   = ~pc;
        bus.id_rd     = rd;
        bus.id_rf_wen = wen;
        for (int k = 0; k < 20 && !acc; k++) begin
            @(negedge clk);
            acc = bus.id_ready;
            @(posedge clk);
            #1;
        end
        bus.id_valid = 1'b0;
        chk("send_accept", 32'(acc), 32'd1);
    endtask

    initial begin
        bus.id_valid  = 1'b0;
        bus.id_pc     = '0;
        bus.id_inst   = '0;
        bus.id_rd     = '0;
        bus.id_rf_wen = 1'b0;
        bus.sb_stall  = 1'b0;
        bus.redirect  = 1'b0;
        bus.ex_ready  = 1'b1;
        idle(2);
        rst = 1'b0;
        idle(1);

        send(32'h8000_0000, 5'd5, 1'b1);
        idle(2);

        // Fill with EX blocked; third instruction waits while full
        bus.ex_ready = 1'b0;
        send(32'h0, 5'd1, 1'b1);
        send(32'h4, 5'd2, 1'b0);
        bus.id_valid  = 1'b1;
        bus.id_pc     = 32'h8;
        bus.id_inst   = ~32'h8;
        bus.id_rd     = 5'd3;
        bus.id_rf_wen = 1'b1;
        idle(3);
        bus.ex_ready = 1'b1;
        send(32'h8, 5'd3, 1'b1);
        idle(3);

        bus.id_valid  = 1'b1;
        bus.id_pc     = 32'h20;
        bus.id_inst   = ~32'h20;
        bus.sb_stall  = 1'b1;
        idle(3);
        bus.sb_stall = 1'b0;
        send(32'h20, 5'd4, 1'b1);
        idle(2);

        // Redirect while full; both entries must drain killed
        bus.ex_ready = 1'b0;
        send(32'h10, 5'd7, 1'b1);
        send(32'h14, 5'd0, 1'b0);
        bus.id_valid  = 1'b1;
        bus.id_pc     = 32'h18;
        bus.id_inst   = ~32'h18;
        bus.redirect  = 1'b1;
        idle(1);
        bus.redirect = 1'b0;
        bus.id_valid = 1'b0;
        idle(1);
        bus.ex_ready = 1'b1;
        idle(3);
        bus.redirect = 1'b1;
        idle(1);
        bus.redirect = 1'b0;
        send(32'h1c, 5'd9, 1'b1);
        idle(2);

        for (int i = 0; i < 10; i++)
            send(32'h100 + 32'(i * 4), 5'(i + 1), i[0]);
        idle(2);

        bus.ex_ready = 1'b0;
        send(32'h40, 5'd1, 1'b1);
        send(32'h44, 5'd2, 1'b1);
        rst = 1'b1;
        idle(1);
        rst = 1'b0;
        bus.ex_ready = 1'b1;
        idle(3);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
